// File: rtl/alu_issue_seq.sv
// Issue sequencer driving a combinational ALU: one request in flight, kLSH iterated ReqRep times.
// Optional completed-operation counter enabled by defining ALU_OPCNT_EN.
module alu_issue_seq #(
  parameter int DW    = 8,
  parameter int REP_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [3:0]       ReqOp,
  input  logic [DW-1:0]    ReqA,
  input  logic [DW-1:0]    ReqB,
  input  logic [REP_W-1:0] ReqRep,
  output logic [DW-1:0]    AluA,
  output logic [DW-1:0]    AluB,
  output logic [3:0]       AluOp,
  input  logic [DW-1:0]    AluOut,
  input  logic             AluZero,
  output logic             ResValid,
  input  logic             ResReady,
  output logic [DW-1:0]    ResData,
  output logic             ResZero,
  output logic             Busy,
  output logic [CNT_W-1:0] OpCount
);

  localparam logic [3:0] kLSH = 4'h4;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_e;

  state_e           state_q;
  logic [REP_W-1:0] rem_q;
  logic [DW-1:0]    alu_a_q, alu_b_q, res_data_q;
  logic [3:0]       alu_op_q;
  logic             res_zero_q, res_valid_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 4'h0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ReqValid) begin
            alu_a_q  <= ReqA;
            alu_b_q  <= ReqB;
            alu_op_q <= ReqOp;
            // remaining extra passes; a zero repeat count still performs one shift
            rem_q    <= (ReqOp == kLSH && ReqRep != '0) ? ReqRep - 1'b1 : '0;
            state_q  <= EXEC;
          end
        end
        EXEC, ITER: begin
          res_data_q <= AluOut;
          res_zero_q <= AluZero;
          if (rem_q == '0) begin
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            alu_a_q <= AluOut;
            rem_q   <= rem_q - 1'b1;
            state_q <= ITER;
          end
        end
        DONE: begin
          if (ResReady) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_OPCNT_EN
  logic [CNT_W-1:0] op_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset)
      op_cnt_q <= '0;
    else if (state_q == DONE && ResReady)
      op_cnt_q <= op_cnt_q + 1'b1;
  end

  assign OpCount = op_cnt_q;
`else
  assign OpCount = '0;
`endif

  assign ReqReady = (state_q == IDLE) && !Reset;
  assign Busy     = (state_q != IDLE);
  assign AluA     = alu_a_q;
  assign AluB     = alu_b_q;
  assign AluOp    = alu_op_q;
  assign ResData  = res_data_q;
  assign ResZero  = res_zero_q;
  assign ResValid = res_valid_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: vector table, multi-cycle corner sequences, random ops.
module tb_alu_issue_seq;

  localparam int DW = 8;
  localparam int REP_W = 3;
  localparam int CNT_W = 16;
`ifdef ALU_OPCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [3:0] kADD = 4'h0, kR_XOR = 4'h1, kXOR = 4'h2, kAND = 4'h3,
                         kLSH = 4'h4, SEQ = 4'h5, SLT = 4'h6, kOR = 4'h7;

  logic             Clk = 1'b0;
  logic             Reset, ReqValid, ReqReady, ResValid, ResReady, ResZero, Busy, AluZero;
  logic [3:0]       ReqOp, AluOp;
  logic [DW-1:0]    ReqA, ReqB, AluA, AluB, AluOut, ResData;
  logic [REP_W-1:0] ReqRep;
  logic [CNT_W-1:0] OpCount;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  alu_issue_seq #(.DW(DW), .REP_W(REP_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB), .ReqRep(ReqRep),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluOut(AluOut), .AluZero(AluZero),
    .ResValid(ResValid), .ResReady(ResReady), .ResData(ResData), .ResZero(ResZero),
    .Busy(Busy), .OpCount(OpCount)
  );

  always #5 Clk = ~Clk;

  // Environment ALU: SEQ/SLT and unknown codes are unimplemented and return 0
  function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      kADD:    return a + b;
      kR_XOR:  return {{(DW-1){1'b0}}, ^a};
      kXOR:    return a ^ b;
      kAND:    return a & b;
      kLSH:    return a << 1;
      kOR:     return a | b;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    AluOut  = alu_f(AluOp, AluA, AluB);
    AluZero = (AluOut == '0);
  end

  // Reference: whole operation in one step, kLSH as a single multi-bit shift
  function automatic logic [DW-1:0] ref_res(input logic [3:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input int rep);
    if (op == kLSH) return a << ((rep == 0) ? 1 : rep);
    return alu_f(op, a, b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
    logic [CNT_W-1:0] e;
    e = CNT_EN ? CNT_W'(exp_cnt) : '0;
    chk(name, 32'(OpCount), 32'(e));
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!ResValid && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    ResReady = 1'b1;
    @(posedge Clk); #1;
    ResReady = 1'b0;
    exp_cnt++;
    chk("valid_drop", 32'(ResValid), 0);
    chk("busy_idle", 32'(Busy), 0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [REP_W-1:0] rep, input int hold,
                        output logic [DW-1:0] d, output logic z, output int lat);
    @(negedge Clk);
    ReqValid = 1'b1; ReqOp = op; ReqA = a; ReqB = b; ReqRep = rep;
    chk("req_ready_idle", 32'(ReqReady), 1);
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    chk("busy_exec", 32'(Busy), 1);
    wait_valid(lat);
    d = ResData;
    z = ResZero;
    repeat (hold) begin
      @(posedge Clk); #1;
      chk("hold_valid", 32'(ResValid), 1);
      chk("hold_data", 32'(ResData), 32'(d));
    end
    handshake();
  endtask

  typedef struct {
    logic [3:0]       op;
    logic [DW-1:0]    a, b;
    logic [REP_W-1:0] rep;
    logic [DW-1:0]    exp_d;
    logic             exp_z;
    int               exp_lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [DW-1:0] d;
    logic z;
    int lat;

    vecs[0]  = '{kADD, 8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 2};
    vecs[1]  = '{SEQ,  8'h05, 8'h05, 3'd0, 8'h00, 1'b1, 2};
    vecs[2]  = '{SLT,  8'h03, 8'h09, 3'd0, 8'h00, 1'b1, 2};
    vecs[3]  = '{kLSH, 8'h81, 8'h00, 3'd3, 8'h08, 1'b0, 4};
    vecs[4]  = '{kLSH, 8'h81, 8'h00, 3'd0, 8'h02, 1'b0, 2};
    vecs[5]  = '{kXOR, 8'hF0, 8'h0F, 3'd5, 8'hFF, 1'b0, 2};
    vecs[6]  = '{kOR,  8'hA0, 8'h05, 3'd0, 8'hA5, 1'b0, 2};
    vecs[7]  = '{kAND, 8'hF0, 8'h0F, 3'd0, 8'h00, 1'b1, 2};
    vecs[8]  = '{4'hF, 8'h12, 8'h34, 3'd2, 8'h00, 1'b1, 2};
    vecs[9]  = '{kLSH, 8'h01, 8'h00, 3'd7, 8'h80, 1'b0, 8};
    vecs[10] = '{kADD, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 2};

    Reset = 1'b1; ReqValid = 1'b0; ResReady = 1'b0;
    ReqOp = '0; ReqA = '0; ReqB = '0; ReqRep = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_req_ready", 32'(ReqReady), 0);
    Reset = 1'b0;
    #1;
    chk("rst_valid", 32'(ResValid), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_alua", 32'(AluA), 0);
    chk("rst_aluop", 32'(AluOp), 0);
    chk("rst_data", 32'(ResData), 0);
    chk("rst_zero", 32'(ResZero), 0);
    chk_cnt("rst_opcount");

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rep, i % 3, d, z, lat);
      chk($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_d));
      chk($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].exp_z));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk_cnt($sformatf("vec%0d_opcount", i));
    end

    // kLSH operand feedback sequence
    @(negedge Clk);
    ReqValid = 1'b1; ReqOp = kLSH; ReqA = 8'h81; ReqB = 8'h00; ReqRep = 3'd3;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    chk("lsh_alua0", 32'(AluA), 32'h81);
    @(posedge Clk); #1;
    chk("lsh_alua1", 32'(AluA), 32'h02);
    @(posedge Clk); #1;
    chk("lsh_alua2", 32'(AluA), 32'h04);
    @(posedge Clk); #1;
    chk("lsh_valid", 32'(ResValid), 1);
    chk("lsh_data", 32'(ResData), 32'h08);
    handshake();

    // Backpressure with a waiting request, then accept right after the handshake
    @(negedge Clk);
    ReqValid = 1'b1; ReqOp = kXOR; ReqA = 8'hF0; ReqB = 8'h0F; ReqRep = '0;
    @(posedge Clk); #1;
    ReqOp = kOR; ReqA = 8'hA0; ReqB = 8'h05;
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 2);
    repeat (5) begin
      @(posedge Clk); #1;
      chk("bp_req_ready", 32'(ReqReady), 0);
      chk("bp_valid", 32'(ResValid), 1);
      chk("bp_data", 32'(ResData), 32'hFF);
    end
    handshake();
    chk("bp_ready_after", 32'(ReqReady), 1);
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    chk("bp_accept_a", 32'(AluA), 32'hA0);
    chk("bp_accept_op", 32'(AluOp), 32'(kOR));
    wait_valid(lat);
    chk("bp_second_data", 32'(ResData), 32'hA5);
    handshake();
    chk_cnt("bp_opcount");

    // Reset mid-iteration aborts the operation
    @(negedge Clk);
    ReqValid = 1'b1; ReqOp = kLSH; ReqA = 8'h01; ReqB = 8'h00; ReqRep = 3'd7;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("abort_req_ready", 32'(ReqReady), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    exp_cnt = 0;
    #1;
    chk("abort_valid", 32'(ResValid), 0);
    chk("abort_busy", 32'(Busy), 0);
    chk("abort_alua", 32'(AluA), 0);
    chk("abort_alub", 32'(AluB), 0);
    chk("abort_data", 32'(ResData), 0);
    chk_cnt("abort_opcount");
    run_op(kOR, 8'hA0, 8'h05, 3'd0, 0, d, z, lat);
    chk("abort_or_data", 32'(d), 32'hA5);
    chk_cnt("abort_or_opcount");

    // Randomized operations against the reference model
    for (int n = 0; n < 200; n++) begin
      logic [3:0] op;
      logic [DW-1:0] a, b;
      logic [REP_W-1:0] rep;
      int elat;
      op  = (($urandom % 4) == 0) ? kLSH : 4'($urandom_range(0, 15));
      a   = DW'($urandom);
      b   = DW'($urandom);
      rep = REP_W'($urandom);
      elat = (op == kLSH) ? 1 + ((rep == 0) ? 1 : int'(rep)) : 2;
      run_op(op, a, b, rep, $urandom_range(0, 3), d, z, lat);
      chk("rnd_data", 32'(d), 32'(ref_res(op, a, b, int'(rep))));
      chk("rnd_zero", 32'(z), 32'(ref_res(op, a, b, int'(rep)) == '0));
      chk("rnd_lat", 32'(lat), 32'(elat));
    end
    chk_cnt("rnd_opcount");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
